// File: rtl/seq_pkg.sv
// Shared types for the parameter sequencer: step-state codes, control phases
// and the bit offsets of the packed LUT entry {state, repeat, length, eof, sof}.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_RST          = 3'd1,
        ST_PANEL_STABLE = 3'd2,
        ST_BACK_BIAS    = 3'd3,
        ST_FLUSH        = 3'd4,
        ST_EXPOSE_TIME  = 3'd5,
        ST_READOUT      = 3'd6,
        ST_AED_DETECT   = 3'd7
    } step_state_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } phase_e;

    localparam int unsigned SOF_BIT = 0;
    localparam int unsigned EOF_BIT = 1;
    localparam int unsigned LEN_LSB = 2;

    function automatic int unsigned entry_w(input int unsigned repeat_w, input int unsigned length_w);
        return 3 + repeat_w + length_w + 2;
    endfunction

    function automatic int unsigned rep_lsb(input int unsigned length_w);
        return LEN_LSB + length_w;
    endfunction

    function automatic int unsigned state_lsb(input int unsigned repeat_w, input int unsigned length_w);
        return LEN_LSB + length_w + repeat_w;
    endfunction

endpackage

// File: rtl/seq_lut_ram.sv
// Sequence LUT: single write port, registered host read and registered fetch read.
// Reads during a same-edge write return the old contents.
module seq_lut_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 29
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    input  logic [AW-1:0] fetch_addr,
    output logic [W-1:0]  fetch_rdata
);

    logic [W-1:0] lut_ram [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            lut_ram[addr] <= wdata;
        end
        rdata       <= lut_ram[addr];
        fetch_rdata <= lut_ram[fetch_addr];
    end

endmodule

// File: rtl/param_sequencer_fsm.sv
// LUT-driven step sequencer. Optional SEQ_LOOP_EN build adds looping back to the
// start address at end-of-frame and the loop_count_o output.
module param_sequencer_fsm
    import seq_pkg::*;
#(
    parameter int LUT_DEPTH = 256,
    parameter int REPEAT_W  = 8,
    parameter int LENGTH_W  = 16,
    parameter int ADDR_W    = $clog2(LUT_DEPTH),
    localparam int ENTRY_W  = 3 + REPEAT_W + LENGTH_W + 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   start_addr_i,
    input  logic                abort_i,
    input  logic                task_done_i,
    input  logic                sensor_stable_i,
    input  logic                adc_ready_i,
    input  logic                aed_detected_i,
    input  logic                loop_en_i,
    input  logic                lut_we_i,
    input  logic [ADDR_W-1:0]   lut_addr_i,
    input  logic [ENTRY_W-1:0]  lut_wdata_i,
    output logic [ENTRY_W-1:0]  lut_rdata_o,
    output logic [2:0]          current_state_o,
    output logic                busy_o,
    output logic                sequence_done_o,
    output logic                seq_err_o,
    output logic                lut_err_o,
`ifdef SEQ_LOOP_EN
    output logic [7:0]          loop_count_o,
`endif
    output logic [REPEAT_W-1:0] current_repeat_count_o,
    output logic [LENGTH_W-1:0] current_data_length_o,
    output logic                current_eof_o,
    output logic                current_sof_o
);

    phase_e              phase, phase_d;
    logic [ADDR_W-1:0]   addr, addr_d, start_addr;
    step_state_e         cur_state;
    logic [REPEAT_W-1:0] cur_rep, rep_cnt;
    logic [LENGTH_W-1:0] cur_len, len_cnt;
    logic                cur_eof, cur_sof;
    logic                seq_err, lut_err;
    logic [ENTRY_W-1:0]  fetch_rdata;
    logic                step_done, len_last, rep_last, at_last, entry_end, loop_now;

    seq_lut_ram #(
        .DEPTH(LUT_DEPTH),
        .AW   (ADDR_W),
        .W    (ENTRY_W)
    ) u_lut (
        .clk        (clk),
        .we         (lut_we_i && !busy_o),
        .addr       (lut_addr_i),
        .wdata      (lut_wdata_i),
        .rdata      (lut_rdata_o),
        .fetch_addr (addr_d),
        .fetch_rdata(fetch_rdata)
    );

    assign busy_o          = (phase != S_IDLE);
    assign sequence_done_o = (phase == S_DONE);
    assign current_state_o = (phase == S_RUN) ? cur_state : ST_IDLE;
    assign seq_err_o       = seq_err;
    assign lut_err_o       = lut_err;
    assign current_repeat_count_o = cur_rep;
    assign current_data_length_o  = cur_len;
    assign current_eof_o          = cur_eof;
    assign current_sof_o          = cur_sof;

    assign len_last  = (cur_len == '0) || (len_cnt == cur_len - LENGTH_W'(1));
    assign rep_last  = (cur_rep == '0) || (rep_cnt == cur_rep - REPEAT_W'(1));
    assign at_last   = (addr == ADDR_W'(LUT_DEPTH - 1));
    assign entry_end = (phase == S_RUN) && !abort_i && step_done && rep_last;

`ifdef SEQ_LOOP_EN
    logic [7:0] loop_cnt;
    assign loop_now     = loop_en_i;
    assign loop_count_o = loop_cnt;
`else
    logic unused_loop_en;
    assign unused_loop_en = loop_en_i;
    assign loop_now       = 1'b0;
`endif

    always_comb begin
        step_done = 1'b0;
        case (cur_state)
            ST_RST, ST_BACK_BIAS, ST_FLUSH, ST_EXPOSE_TIME: step_done = task_done_i;
            ST_PANEL_STABLE: step_done = sensor_stable_i;
            ST_READOUT:      step_done = adc_ready_i && len_last;
            ST_AED_DETECT:   step_done = aed_detected_i || task_done_i;
            ST_IDLE:         step_done = 1'b1;
            default:         step_done = 1'b1;
        endcase
    end

    // addr_d also drives the fetch read port, so the entry is ready during S_FETCH.
    always_comb begin
        phase_d = phase;
        addr_d  = addr;
        case (phase)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = start_addr_i;
                    phase_d = S_FETCH;
                end
            end
            S_FETCH: phase_d = abort_i ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort_i) begin
                    phase_d = S_IDLE;
                end else if (entry_end) begin
                    if (cur_eof || at_last) begin
                        if (loop_now) begin
                            addr_d  = start_addr;
                            phase_d = S_FETCH;
                        end else begin
                            phase_d = S_DONE;
                        end
                    end else begin
                        addr_d  = addr + ADDR_W'(1);
                        phase_d = S_FETCH;
                    end
                end
            end
            S_DONE:  phase_d = S_IDLE;
            default: phase_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= S_IDLE;
            addr       <= '0;
            start_addr <= '0;
            cur_state  <= ST_IDLE;
            cur_rep    <= '0;
            cur_len    <= '0;
            cur_eof    <= 1'b0;
            cur_sof    <= 1'b0;
            rep_cnt    <= '0;
            len_cnt    <= '0;
            seq_err    <= 1'b0;
            lut_err    <= 1'b0;
        end else begin
            phase   <= phase_d;
            addr    <= addr_d;
            seq_err <= 1'b0;
            lut_err <= lut_we_i && busy_o;
            if (phase == S_IDLE && start_i) begin
                start_addr <= start_addr_i;
            end
            if (phase == S_FETCH && !abort_i) begin
                cur_state <= step_state_e'(fetch_rdata[state_lsb(REPEAT_W, LENGTH_W) +: 3]);
                cur_rep   <= fetch_rdata[rep_lsb(LENGTH_W) +: REPEAT_W];
                cur_len   <= fetch_rdata[LEN_LSB +: LENGTH_W];
                cur_eof   <= fetch_rdata[EOF_BIT];
                cur_sof   <= fetch_rdata[SOF_BIT];
                rep_cnt   <= '0;
                len_cnt   <= '0;
            end
            if (phase == S_RUN && !abort_i) begin
                if (cur_state == ST_READOUT && adc_ready_i && !len_last) begin
                    len_cnt <= len_cnt + LENGTH_W'(1);
                end
                if (step_done) begin
                    len_cnt <= '0;
                    rep_cnt <= rep_last ? '0 : rep_cnt + REPEAT_W'(1);
                    if (cur_state == ST_IDLE || (rep_last && at_last && !cur_eof)) begin
                        seq_err <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef SEQ_LOOP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            loop_cnt <= '0;
        end else if (phase == S_IDLE && start_i) begin
            loop_cnt <= '0;
        end else if (entry_end && (cur_eof || at_last) && loop_en_i && loop_cnt != 8'hFF) begin
            loop_cnt <= loop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_param_sequencer_fsm.sv
// Scoreboard bench for param_sequencer_fsm: directed sequences push expected
// events; a negedge monitor turns DUT activity into events and compares them.
module tb_param_sequencer_fsm;

    localparam int K_STEP = 1, K_SEQERR = 2, K_LUTERR = 3, K_DONE = 4,
                   K_BUSY = 5, K_PROBE = 6, K_RDATA = 7;

    typedef struct {
        int              kind;
        longint unsigned val;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  start_addr_i = '0;
    logic        abort_i = 1'b0;
    logic        task_done_i = 1'b0, sensor_stable_i = 1'b0, adc_ready_i = 1'b0, aed_detected_i = 1'b0;
    logic        loop_en_i = 1'b0;
    logic        lut_we_i = 1'b0;
    logic [7:0]  lut_addr_i = '0;
    logic [28:0] lut_wdata_i = '0;
    logic [28:0] lut_rdata_o;
    logic [2:0]  current_state_o;
    logic        busy_o, sequence_done_o, seq_err_o, lut_err_o;
    logic [7:0]  current_repeat_count_o;
    logic [15:0] current_data_length_o;
    logic        current_eof_o, current_sof_o;
`ifdef SEQ_LOOP_EN
    logic [7:0]  loop_count_o;
`endif

    logic probe = 1'b0, rd_req = 1'b0;
    ev_t  exp_q[$];
    int   checks = 0, failures = 0;

    param_sequencer_fsm dut (
        .clk(clk), .reset(reset), .start_i(start_i), .start_addr_i(start_addr_i),
        .abort_i(abort_i), .task_done_i(task_done_i), .sensor_stable_i(sensor_stable_i),
        .adc_ready_i(adc_ready_i), .aed_detected_i(aed_detected_i), .loop_en_i(loop_en_i),
        .lut_we_i(lut_we_i), .lut_addr_i(lut_addr_i), .lut_wdata_i(lut_wdata_i),
        .lut_rdata_o(lut_rdata_o), .current_state_o(current_state_o), .busy_o(busy_o),
        .sequence_done_o(sequence_done_o), .seq_err_o(seq_err_o), .lut_err_o(lut_err_o),
`ifdef SEQ_LOOP_EN
        .loop_count_o(loop_count_o),
`endif
        .current_repeat_count_o(current_repeat_count_o),
        .current_data_length_o(current_data_length_o),
        .current_eof_o(current_eof_o), .current_sof_o(current_sof_o)
    );

    always #5 clk = ~clk;

    function automatic logic [28:0] mk(input logic [2:0] st, input logic [7:0] rep,
                                       input logic [15:0] len, input logic eof, input logic sof);
        return {st, rep, len, eof, sof};
    endfunction

    function automatic longint unsigned pv(input logic [7:0] lc, input logic busy, input logic [2:0] cs,
                                           input logic done, input logic se, input logic le,
                                           input logic [7:0] rep, input logic [15:0] len,
                                           input logic eof, input logic sof);
        return {16'h0, lc, 7'h0, busy, cs, done, se, le, rep, len, eof, sof};
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_STEP:   return "step";
            K_SEQERR: return "seq_err_pulse";
            K_LUTERR: return "lut_err_pulse";
            K_DONE:   return "done_pulse";
            K_BUSY:   return "busy_after_done";
            K_PROBE:  return "probe";
            K_RDATA:  return "lut_rdata";
            default:  return "unknown";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input longint unsigned val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic emit(input int kind, input longint unsigned val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s actual=%0h required=no event", kname(kind), val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                failures++;
                $display("FAIL %s actual=%s:%0h required=%s:%0h", kname(e.kind), kname(kind), val,
                         kname(e.kind), e.val);
            end
        end
    endtask

    // Monitor: step runs (state, completion pulses seen), pulse widths, probes, reads.
    initial begin
        logic [2:0] run_state = '0;
        int run_cnt = 0, se_len = 0, le_len = 0, dn_len = 0;
        logic rd_pend = 1'b0;
        logic comp;
        logic [7:0] lc;
        forever begin
            @(negedge clk);
            if (current_state_o != run_state) begin
                if (run_state != 3'd0) emit(K_STEP, longint'(run_state) * 256 + longint'(run_cnt));
                run_state = current_state_o;
                run_cnt   = 0;
            end
            case (current_state_o)
                3'd2:    comp = sensor_stable_i;
                3'd6:    comp = adc_ready_i;
                3'd7:    comp = aed_detected_i || task_done_i;
                3'd0:    comp = 1'b0;
                default: comp = task_done_i;
            endcase
            if (comp) run_cnt++;
            if (seq_err_o) se_len++;
            else if (se_len > 0) begin emit(K_SEQERR, longint'(se_len)); se_len = 0; end
            if (lut_err_o) le_len++;
            else if (le_len > 0) begin emit(K_LUTERR, longint'(le_len)); le_len = 0; end
            if (sequence_done_o) dn_len++;
            else if (dn_len > 0) begin
                emit(K_DONE, longint'(dn_len));
                emit(K_BUSY, longint'(busy_o));
                dn_len = 0;
            end
`ifdef SEQ_LOOP_EN
            lc = loop_count_o;
`else
            lc = 8'h0;
`endif
            if (probe) emit(K_PROBE, pv(lc, busy_o, current_state_o, sequence_done_o, seq_err_o, lut_err_o,
                                        current_repeat_count_o, current_data_length_o,
                                        current_eof_o, current_sof_o));
            if (rd_pend) emit(K_RDATA, longint'(lut_rdata_o));
            rd_pend = rd_req;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout_fail(input string what);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=completion", what);
    endtask

    task automatic lut_write(input logic [7:0] a, input logic [28:0] d);
        lut_we_i = 1'b1; lut_addr_i = a; lut_wdata_i = d;
        cyc();
        lut_we_i = 1'b0;
    endtask

    task automatic lut_read(input logic [7:0] a);
        lut_addr_i = a; rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        cyc();
    endtask

    task automatic do_probe();
        probe = 1'b1;
        cyc();
        probe = 1'b0;
    endtask

    task automatic start_seq(input logic [7:0] a);
        start_addr_i = a; start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s);
        for (int i = 0; i < 100; i++) begin
            if (current_state_o == s) return;
            cyc();
        end
        timeout_fail("wait_state");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy_o) return;
            cyc();
        end
        timeout_fail("wait_idle");
    endtask

    // mode 0: task_done every 3rd cycle; 1: adc_ready every 2nd; 2: sensor/aed staggered
    task automatic run_seq(input logic [7:0] a, input int mode);
        start_seq(a);
        for (int i = 0; i < 400; i++) begin
            task_done_i     = (mode == 0) && (i % 3 == 2);
            adc_ready_i     = (mode == 1) && (i % 2 == 1);
            sensor_stable_i = (mode == 2) && (i % 4 == 3);
            aed_detected_i  = (mode == 2) && (i % 5 == 4);
            cyc();
            if (!busy_o) begin
                {task_done_i, adc_ready_i, sensor_stable_i, aed_detected_i} = '0;
                repeat (3) cyc();
                return;
            end
        end
        {task_done_i, adc_ready_i, sensor_stable_i, aed_detected_i} = '0;
        timeout_fail("run_seq");
    endtask

    task automatic pulse_td();
        task_done_i = 1'b1;
        cyc();
        task_done_i = 1'b0;
    endtask

    initial begin
        ev_t e;
        repeat (3) cyc();
        reset = 1'b0;
        expect_ev(K_PROBE, 64'h0);
        do_probe();

        lut_write(8'd0, mk(3'd1, 8'd1, 16'd0, 1'b0, 1'b1));
        lut_write(8'd1, mk(3'd4, 8'd2, 16'd0, 1'b0, 1'b0));
        lut_write(8'd2, mk(3'd5, 8'd1, 16'd0, 1'b1, 1'b0));
        lut_write(8'd8, mk(3'd6, 8'd2, 16'd3, 1'b1, 1'b1));
        lut_write(8'd16, mk(3'd1, 8'd1, 16'd0, 1'b1, 1'b0));
        lut_write(8'd20, mk(3'd1, 8'd1, 16'd0, 1'b1, 1'b0));
        lut_write(8'd40, mk(3'd0, 8'd1, 16'd0, 1'b1, 1'b0));
        lut_write(8'd48, mk(3'd2, 8'd1, 16'd0, 1'b0, 1'b0));
        lut_write(8'd49, mk(3'd7, 8'd1, 16'd0, 1'b1, 1'b0));
        lut_write(8'd255, mk(3'd1, 8'd1, 16'd0, 1'b0, 1'b0));

        // RST, FLUSH x2, EXPOSE_TIME, then one done pulse and busy low
        expect_ev(K_STEP, 64'h101); expect_ev(K_STEP, 64'h402); expect_ev(K_STEP, 64'h501);
        expect_ev(K_DONE, 1); expect_ev(K_BUSY, 0);
        run_seq(8'd0, 0);

        // READOUT length 3 repeat 2 leaves after exactly 6 adc_ready pulses
        expect_ev(K_STEP, 64'h606); expect_ev(K_DONE, 1); expect_ev(K_BUSY, 0);
        run_seq(8'd8, 1);

        expect_ev(K_STEP, 64'h201); expect_ev(K_STEP, 64'h701); expect_ev(K_DONE, 1); expect_ev(K_BUSY, 0);
        run_seq(8'd48, 2);

        // IDLE code inside an entry: immediate completion with seq_err
        expect_ev(K_SEQERR, 1); expect_ev(K_DONE, 1); expect_ev(K_BUSY, 0);
        run_seq(8'd40, 0);

        // last address without eof: seq_err plus done, no wrap to entry 0
        expect_ev(K_STEP, 64'h101); expect_ev(K_SEQERR, 1); expect_ev(K_DONE, 1); expect_ev(K_BUSY, 0);
        run_seq(8'd255, 0);

        // abort together with the final completion: idle next cycle, no done
        expect_ev(K_STEP, 64'h101);
        expect_ev(K_PROBE, pv(8'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1, 16'd0, 1'b1, 1'b0));
        start_seq(8'd16);
        wait_state(3'd1);
        task_done_i = 1'b1; abort_i = 1'b1;
        cyc();
        task_done_i = 1'b0; abort_i = 1'b0;
        do_probe();
        repeat (4) cyc();

        // write while busy is refused and flagged; entry keeps its old value
        expect_ev(K_LUTERR, 1); expect_ev(K_STEP, 64'h101); expect_ev(K_DONE, 1); expect_ev(K_BUSY, 0);
        expect_ev(K_RDATA, longint'(mk(3'd1, 8'd1, 16'd0, 1'b1, 1'b0)));
        start_seq(8'd20);
        wait_state(3'd1);
        lut_write(8'd20, mk(3'd7, 8'd9, 16'd99, 1'b0, 1'b1));
        repeat (3) cyc();
        pulse_td();
        wait_idle();
        repeat (3) cyc();
        lut_read(8'd20);

        // read during a same-edge write returns the old word
        lut_write(8'd30, 29'h0AAAA55);
        expect_ev(K_RDATA, 64'h0AAAA55);
        lut_we_i = 1'b1; lut_addr_i = 8'd30; lut_wdata_i = 29'h1234567; rd_req = 1'b1;
        cyc();
        lut_we_i = 1'b0; rd_req = 1'b0;
        cyc();
        expect_ev(K_RDATA, 64'h1234567);
        lut_read(8'd30);

        // reset mid-sequence abandons it without a done pulse and clears outputs
        expect_ev(K_STEP, 64'h100); expect_ev(K_PROBE, 64'h0);
        start_seq(8'd0);
        wait_state(3'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        do_probe();
        repeat (4) cyc();

`ifdef SEQ_LOOP_EN
        // two loop passes then a normal finish
        expect_ev(K_STEP, 64'h101); expect_ev(K_STEP, 64'h101); expect_ev(K_STEP, 64'h101);
        expect_ev(K_DONE, 1); expect_ev(K_BUSY, 0);
        expect_ev(K_PROBE, pv(8'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1, 16'd0, 1'b1, 1'b0));
        loop_en_i = 1'b1;
        start_seq(8'd16);
        wait_state(3'd1); pulse_td();
        wait_state(3'd1); pulse_td();
        loop_en_i = 1'b0;
        wait_state(3'd1); pulse_td();
        wait_idle();
        repeat (2) cyc();
        do_probe();
`endif

        repeat (10) cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_%s actual=none required=%0h", kname(e.kind), e.val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_sequencer_fsm.md
PARAM_SEQUENCER_FSM -- requirements
Module: param_sequencer_fsm

Interface
REQ-001 Parameter LUT_DEPTH, default 256: number of LUT entries; power of two, 16..1024.
REQ-002 Parameter REPEAT_W, default 8: repeat-count field width.
REQ-003 Parameter LENGTH_W, default 16: data-length field width.
REQ-004 Parameter ADDR_W, default $clog2(LUT_DEPTH): LUT address width.
REQ-005 Entry width SHALL be ENTRY_W = 3+REPEAT_W+LENGTH_W+2, packed MSB-first as {state[2:0], repeat_count, data_length, eof, sof}; the default is 29 bits.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start_i  in  1  one-cycle request to start a sequence.
REQ-009 start_addr_i  in  ADDR_W  first LUT entry of the sequence.
REQ-010 abort_i  in  1  terminates the running sequence.
REQ-011 task_done_i, sensor_stable_i, adc_ready_i, aed_detected_i  in  1 each  step-completion events.
REQ-012 loop_en_i  in  1  loop request; used only when SEQ_LOOP_EN is defined.
REQ-013 lut_we_i  in  1, lut_addr_i  in  ADDR_W, lut_wdata_i  in  ENTRY_W: LUT write/read port.
REQ-014 lut_rdata_o  out  ENTRY_W  registered read data at lut_addr_i.
REQ-015 current_state_o  out  3, busy_o  out  1, sequence_done_o  out  1, seq_err_o  out  1, lut_err_o  out  1.
REQ-016 current_repeat_count_o  out  REPEAT_W, current_data_length_o  out  LENGTH_W, current_eof_o  out  1, current_sof_o  out  1: fields of the active entry.
REQ-017 loop_count_o  out  8  completed loops; present only with SEQ_LOOP_EN.

Function
REQ-018 State codes SHALL be IDLE=0, RST=1, PANEL_STABLE=2, BACK_BIAS=3, FLUSH=4, EXPOSE_TIME=5, READOUT=6, AED_DETECT=7.
REQ-019 The control FSM SHALL have phases S_IDLE, S_FETCH, S_RUN and S_DONE.
REQ-020 S_IDLE: start_i=1 SHALL latch start_addr_i and go to S_FETCH; busy_o goes high on the next cycle.
REQ-021 S_FETCH: one cycle for the synchronous RAM read; the entry is latched into the current-field outputs on entry to S_RUN.
REQ-022 S_RUN: current_state_o = the entry state field. Step completion events per state:
- RST, BACK_BIAS, FLUSH, EXPOSE_TIME: task_done_i.
- PANEL_STABLE: sensor_stable_i.
- READOUT: the data_length-th adc_ready_i pulse; data_length 0 completes on the first pulse.
- AED_DETECT: aed_detected_i or task_done_i (timeout).
- IDLE code in an entry: step completes immediately and seq_err_o pulses.
REQ-023 Each step SHALL execute max(repeat_count,1) times; internal counters SHALL be REPEAT_W and LENGTH_W wide with no overflow.
REQ-024 After the final repeat, if eof=0 the FSM SHALL go to S_FETCH at address+1.
REQ-025 After the final repeat, if eof=1 the FSM SHALL go to S_DONE.
REQ-026 If an entry at LUT_DEPTH-1 with eof=0 completes, the FSM SHALL treat it as eof, pulse seq_err_o for 1 cycle and not wrap.
REQ-027 S_DONE SHALL pulse sequence_done_o for exactly 1 cycle, then return to S_IDLE with busy_o=0.
REQ-028 abort_i in S_FETCH or S_RUN SHALL go to S_IDLE next cycle with no sequence_done_o; abort wins over a simultaneous step completion.
REQ-029 start_i while busy_o=1 SHALL be ignored.
REQ-030 lut_we_i while busy_o=0 SHALL write on that edge.
REQ-031 lut_we_i while busy_o=1 SHALL NOT write and SHALL pulse lut_err_o.
REQ-032 A read SHALL return lut_rdata_o one cycle after lut_addr_i is presented; a read during a same-cycle write SHALL return the old data.
REQ-033 In S_IDLE, current_state_o SHALL be 0 and the field outputs SHALL hold their last values.

Reset
REQ-034 With reset=1 at a clock edge, the FSM SHALL enter S_IDLE.
REQ-035 On reset, all outputs except lut_rdata_o SHALL be 0 and all counters SHALL clear.
REQ-036 Reset SHALL NOT clear the LUT contents; reset mid-sequence SHALL abandon the sequence with no done pulse.

Configuration
REQ-037 When SEQ_LOOP_EN is defined: at eof with loop_en_i=1, the FSM SHALL refetch the latched start address instead of entering S_DONE and SHALL increment loop_count_o (saturating at 255).
REQ-038 When SEQ_LOOP_EN is defined: loop_count_o SHALL clear on start_i.
REQ-039 When SEQ_LOOP_EN is undefined: loop_en_i SHALL be ignored and loop_count_o SHALL be absent.

Structure
REQ-040 Package seq_pkg SHALL hold the state enum, the parametrised entry field offsets and the phase enum.
REQ-041 The LUT RAM SHALL be the sub-module seq_lut_ram (single-port write, registered read, array named lut_ram) so benches can preload it hierarchically.

Verification
REQ-042 Preload entries 0..2 = {RST,1,0,0,1}, {FLUSH,2,0,0,0}, {EXPOSE_TIME,1,0,1,0}; start at 0; task_done_i every 3rd cycle -> state sequence 1,4,4,5; one sequence_done_o pulse; busy_o low the following cycle.
REQ-043 READOUT entry with data_length=3, repeat 2 -> exit after the 6th adc_ready_i pulse, not before.
REQ-044 abort_i asserted together with the task_done_i that would complete the last step -> no done pulse; IDLE next cycle.
REQ-045 lut_we_i while busy -> lut_err_o=1 for 1 cycle; readback after idle shows the old entry unchanged.
REQ-046 Last-address entry with eof=0 -> seq_err_o pulse plus sequence_done_o; the address does not wrap to 0.
REQ-047 SEQ_LOOP_EN defined, loop_en_i=1 for 2 passes then 0 -> loop_count_o=2, then done.
